// File: rtl/soc_mem_arbiter_if.sv
// Bundle of the three requester ports, the shared read response and the RAM port.
// The arbiter uses the slave view; the core/loader/RAM side uses the master view.
interface soc_mem_arbiter_if #(
    parameter int AW = 12
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;

    logic          ls_req;
    logic          ls_we;
    logic [3:0]    ls_be;
    logic [AW-1:0] ls_addr;
    logic [31:0]   ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;

    logic          dbg_req;
    logic          dbg_lock;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;

    logic [31:0]   rsp_rdata;
    logic          core_hold;

    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, ls_gnt, ls_rvalid, dbg_gnt, dbg_rvalid,
        output rsp_rdata, core_hold,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, dbg_gnt, dbg_rvalid,
        input  rsp_rdata, core_hold,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/soc_mem_arbiter.sv
// Per-cycle arbiter sharing one single-port RAM between fetch, load/store and debug,
// with a fetch-starvation guard and a debug bus lock for burst loads.
module soc_mem_arbiter #(
    parameter int AW       = 12,
    parameter int MAX_WAIT = 3,
    parameter int CW       = 2
) (
    input  logic              clk,
    input  logic              rst,
    soc_mem_arbiter_if.slave  bus
);
    localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);

    logic [CW-1:0] r_starv_cnt;
    logic          r_lock;
    logic          r_if_rvalid_p1;
    logic          r_ls_rvalid_p1;
    logic          r_dbg_rvalid_p1;

    logic          w_if_force;
    logic          w_if_gnt;
    logic          w_ls_gnt;
    logic          w_dbg_gnt;
    logic          w_mem_we;
    logic [3:0]    w_mem_be;
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_wdata;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign w_if_force = bus.if_req && (r_starv_cnt == MAX_WAIT_C);

    // DBG > LS > IF, except a starved IF overtakes LS; the lock shuts out the core entirely
    always_comb begin
        w_dbg_gnt = ~rst & bus.dbg_req;
        w_ls_gnt  = ~rst & ~r_lock & ~bus.dbg_req & bus.ls_req & ~w_if_force;
        w_if_gnt  = ~rst & ~r_lock & ~bus.dbg_req & bus.if_req & ~w_ls_gnt;
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_be    = 4'h0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_dbg_gnt) begin
            w_mem_we    = bus.dbg_we;
            w_mem_be    = 4'hF;
            w_mem_addr  = bus.dbg_addr;
            w_mem_wdata = bus.dbg_wdata;
        end else if (w_ls_gnt) begin
            w_mem_we    = bus.ls_we;
            w_mem_be    = bus.ls_be;
            w_mem_addr  = bus.ls_addr;
            w_mem_wdata = bus.ls_wdata;
        end else if (w_if_gnt) begin
            w_mem_be    = 4'hF;
            w_mem_addr  = bus.if_addr;
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.ls_gnt    = w_ls_gnt;
    assign bus.dbg_gnt   = w_dbg_gnt;
    assign bus.mem_en    = w_if_gnt | w_ls_gnt | w_dbg_gnt;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_be    = w_mem_be;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.rsp_rdata = bus.mem_rdata;
    assign bus.core_hold = r_lock | (bus.if_req & ~w_if_gnt) | (bus.ls_req & ~w_ls_gnt);

    // Masked by rst so a read granted just before reset never reports completion
    assign bus.if_rvalid  = r_if_rvalid_p1  & ~rst;
    assign bus.ls_rvalid  = r_ls_rvalid_p1  & ~rst;
    assign bus.dbg_rvalid = r_dbg_rvalid_p1 & ~rst;

    // Stage boundary: grant cycle -> response cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starv_cnt     <= '0;
            r_lock          <= 1'b0;
            r_if_rvalid_p1  <= 1'b0;
            r_ls_rvalid_p1  <= 1'b0;
            r_dbg_rvalid_p1 <= 1'b0;
        end else begin
            if (!bus.if_req || w_if_gnt)
                r_starv_cnt <= '0;
            else
                r_starv_cnt <= sat_inc(r_starv_cnt);

            if (!bus.dbg_lock)
                r_lock <= 1'b0;
            else if (w_dbg_gnt)
                r_lock <= 1'b1;

            r_if_rvalid_p1  <= w_if_gnt;
            r_ls_rvalid_p1  <= w_ls_gnt & ~bus.ls_we;
            r_dbg_rvalid_p1 <= w_dbg_gnt & ~bus.dbg_we;
        end
    end
endmodule

// File: doc/soc_mem_arbiter.md
Name: soc_mem_arbiter

Overview:
- Shares one single-port 32-bit data/instruction RAM between three requesters: core instruction fetch (IF), core load/store (LS) and the test/debug loader (DBG).
- DBG preloads programs and inspects results.
- Sits in riscv_soc between riscv_core and the RAM.
- Per-cycle grant with a one-cycle registered read response, fetch-starvation guard, and a DBG bus lock for burst loads while the core is held.

Parameters:
AW, 12, word-address width of the RAM
MAX_WAIT, 3, consecutive cycles IF may lose to LS before IF is forced to win
CW, 2, width of the starvation counter (2^CW-1 >= MAX_WAIT)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request (read only)
if_addr  in  AW  fetch word address
if_gnt  out  1  fetch granted this cycle
if_rvalid  out  1  rsp_rdata valid for IF
ls_req  in  1  load/store request
ls_we  in  1  1=write, 0=read
ls_be  in  4  byte enables for writes
ls_addr  in  AW  word address
ls_wdata  in  32  write data
ls_gnt  out  1  LS granted
ls_rvalid  out  1  rsp_rdata valid for LS
dbg_req  in  1  debug request
dbg_lock  in  1  hold bus for DBG after this grant
dbg_we  in  1  1=write
dbg_addr  in  AW  word address
dbg_wdata  in  32  write data (full word)
dbg_gnt  out  1  DBG granted
dbg_rvalid  out  1  rsp_rdata valid for DBG
rsp_rdata  out  32  shared read data (= mem_rdata)
core_hold  out  1  stall to core pipeline
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_be  out  4  RAM byte enables
mem_addr  out  AW  RAM word address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid one cycle after a read enable

Behaviour:
- Grants are combinational from the current requests and registered state. At most one gnt is high per cycle.
- mem_* are driven from the winner. mem_en = OR of gnts. When no requester wins, mem_we = 0 and mem_be = 0.
- DBG writes drive mem_be = 4'hF. IF reads drive mem_we = 0.
- Priority: DBG > LS > IF.
  - Exception: when starv_cnt == MAX_WAIT and if_req is high, IF beats LS. DBG still beats IF.
- starv_cnt update:
  - +1 (saturating) in each cycle with if_req=1 and if_gnt=0.
  - Cleared on if_gnt, or when if_req=0.
- lock_q:
  - Set on a cycle with dbg_gnt=1 and dbg_lock=1.
  - Cleared on any cycle where dbg_lock=0.
  - While lock_q=1, if_gnt = ls_gnt = 0 regardless of requests. DBG is granted whenever dbg_req=1. With dbg_req=0, mem_en = 0.
- Read response:
  - x_rvalid is registered. It is 1 in cycle N+1 iff x was granted a read in cycle N.
  - rsp_rdata = mem_rdata, combinational pass-through.
  - No rvalid is produced for writes; a write completes in its grant cycle.
- Back-to-back: a new grant is allowed in the same cycle that a previous read's rvalid is high. Throughput is 1 access/cycle.
- core_hold = lock_q | (if_req & ~if_gnt) | (ls_req & ~ls_gnt).
- Requesters hold req/addr/data stable until their gnt. Dropping req before gnt is legal: no access occurs.
- Reset (rst=1 at a clock edge):
  - starv_cnt=0, lock_q=0, all rvalid=0.
  - During the rst cycle all gnt=0 and mem_en=0.
  - A read granted in the cycle before reset produces no rvalid.
- Simultaneous dbg_lock deassert and dbg_req: DBG is granted normally (priority). lock_q clears at that edge.

Test Plan:
- Reset: hold rst 2 cycles with all req=1 -> all gnt=0, mem_en=0, rvalid=0. First cycle after release: dbg_gnt=1.
- IF alone: if_req=1, addr 0x000..0x003, RAM preloaded 0x00000013 / 0x00100093 / ... -> if_gnt=1 every cycle; if_rvalid=1 one cycle later with matching rsp_rdata; core_hold=0.
- LS vs IF contention: both req continuously, MAX_WAIT=3 -> LS granted 3 cycles, IF granted on the 4th, then the pattern repeats; starv_cnt clears on each if_gnt.
- LS byte write: ls_we=1, be=4'b0010, addr 0x010, wdata 0xAABBCCDD, then LS read of 0x010 -> mem_be=0010 in the write cycle; the read returns old word with byte1=0xCC, ls_rvalid one cycle after grant.
- DBG lock burst: dbg_lock=1, write 4 words with dbg_req gaps and if_req=1 throughout -> if_gnt=0 and core_hold=1 for the whole burst including gaps; after dbg_lock=0, if_gnt=1 on the next cycle.
- Reset mid-read: LS read granted in cycle N, rst=1 in cycle N+1 -> ls_rvalid=0 in N+1 and afterwards until a new grant.
